// File: rtl/posit_stream_pkg.sv
// Shared types and constants for posit stream <-> memory converters.
package posit_stream_pkg;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  // Bits needed to hold a word count of 0..depth
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Posit zero is the all-zeros pattern; used to pad short frames
  localparam logic POSIT_ZERO_BIT = 1'b0;

endpackage

// File: rtl/stream_to_memory.sv
// Serial posit stream to parallel frame deserializer: fills a register bank,
// then presents it as one frame until the consumer takes it.
module stream_to_memory
  import posit_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 20,
  localparam int CNT_W = count_width(MEMORY_DEPTH),
  localparam int PTR_W = $clog2(MEMORY_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               rtr_o,
  input  logic                               rts_i,
  input  logic                               eow_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               rtr_i,
  output logic                               rts_o,
  output logic                               eow_o,
  output logic [CNT_W-1:0]                   count_o,
  output logic [DATA_WIDTH*MEMORY_DEPTH-1:0] data_o
);

  state_e                                    state, state_nxt;
  logic [PTR_W-1:0]                          ptr;
  logic [CNT_W-1:0]                          count;
  logic                                      eow_flag;
  logic [MEMORY_DEPTH-1:0][DATA_WIDTH-1:0]   mem;
  logic                                      accept, last;

  assign accept = rts_i && (state == FILL);
  assign last   = eow_i || (ptr == PTR_W'(MEMORY_DEPTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && last) state_nxt = HOLD;
      HOLD: if (rtr_i)          state_nxt = FILL;
      default:                  state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      ptr      <= '0;
      count    <= '0;
      eow_flag <= 1'b0;
      mem      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem[ptr] <= data_i;
        if (last) begin
          count    <= CNT_W'(ptr) + CNT_W'(1);
          eow_flag <= eow_i;
          ptr      <= '0;
        end else begin
          ptr <= ptr + PTR_W'(1);
        end
      end
      // Clearing on frame release gives zero padding for the next short frame
      if (state == HOLD && rtr_i) begin
        mem      <= {(MEMORY_DEPTH*DATA_WIDTH){POSIT_ZERO_BIT}};
        count    <= '0;
        eow_flag <= 1'b0;
      end
    end
  end

  assign rtr_o   = (state == FILL);
  assign rts_o   = (state == HOLD);
  assign eow_o   = eow_flag;
  assign count_o = count;
  assign data_o  = mem;

endmodule

// File: tb/tb_stream_to_memory.sv
// Directed bench for stream_to_memory (DATA_WIDTH=16, MEMORY_DEPTH=4) with a
// cycle model that pushes expected frames into a scoreboard queue.
module tb_stream_to_memory;

  localparam int DW = 16;
  localparam int MD = 4;

  typedef struct {
    logic [DW*MD-1:0] data;
    int               cnt;
    logic             eow;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rtr_o, rts_i, eow_i, rtr_i, rts_o, eow_o;
  logic [DW-1:0]     data_i;
  logic [2:0]        count_o;
  logic [DW*MD-1:0]  data_o;

  int checks = 0;
  int failures = 0;

  frame_t           sb[$];
  logic             m_hold;
  int               m_ptr;
  logic [MD-1:0][DW-1:0] m_mem;
  int               rtr_low;
  logic [DW*MD-1:0] held_data;

  stream_to_memory #(.DATA_WIDTH(DW), .MEMORY_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .eow_i(eow_i),
    .data_i(data_i), .rtr_i(rtr_i), .rts_o(rts_o), .eow_o(eow_o),
    .count_o(count_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hold = 1'b0;
    m_ptr  = 0;
    m_mem  = '0;
    sb.delete();
  endtask

  // Called at a negedge: check outputs against the model, drive, clock, update model.
  task automatic step(input logic rts, input logic eow, input logic [DW-1:0] d, input logic rtr);
    frame_t f;
    chk("rtr_o", {63'd0, rtr_o}, {63'd0, !m_hold});
    chk("rts_o", {63'd0, rts_o}, {63'd0, m_hold});
    if (!rtr_o) rtr_low++;
    if (m_hold && sb.size() != 0) begin
      chk("frame_data", data_o, sb[0].data);
      chk("frame_cnt", {61'd0, count_o}, 64'(sb[0].cnt));
      chk("frame_eow", {63'd0, eow_o}, {63'd0, sb[0].eow});
    end else if (!m_hold) begin
      chk("idle_cnt", {61'd0, count_o}, 64'd0);
      chk("idle_eow", {63'd0, eow_o}, 64'd0);
    end
    rts_i = rts; eow_i = eow; data_i = d; rtr_i = rtr;
    @(posedge clk);
    if (m_hold) begin
      if (rtr) begin
        void'(sb.pop_front());
        m_hold = 1'b0;
        m_mem  = '0;
      end
    end else if (rts) begin
      m_mem[m_ptr] = d;
      if (eow || m_ptr == MD - 1) begin
        f.data = m_mem;
        f.cnt  = m_ptr + 1;
        f.eow  = eow;
        sb.push_back(f);
        m_hold = 1'b1;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rts_i = 1'b0; eow_i = 1'b0; data_i = '0; rtr_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_rts", {63'd0, rts_o}, 64'd0);
    chk("rst_rtr", {63'd0, rtr_o}, 64'd1);
    chk("rst_cnt", {61'd0, count_o}, 64'd0);
    chk("rst_data", data_o, 64'd0);

    // full frame
    rtr_low = 0;
    step(1, 0, 16'h1111, 1);
    step(1, 0, 16'h2222, 1);
    step(1, 0, 16'h3333, 1);
    step(1, 0, 16'h4444, 1);
    chk("full_rts", {63'd0, rts_o}, 64'd1);
    chk("full_data", data_o, 64'h4444_3333_2222_1111);
    chk("full_cnt", {61'd0, count_o}, 64'd4);
    chk("full_eow", {63'd0, eow_o}, 64'd0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    chk("full_rtr_low_cycles", 64'(rtr_low), 64'd1);

    // short frame after a full one: padding must be zero
    step(1, 0, 16'h00AA, 1);
    step(1, 1, 16'h00BB, 1);
    chk("short_data", data_o, 64'h0000_0000_00BB_00AA);
    chk("short_cnt", {61'd0, count_o}, 64'd2);
    chk("short_eow", {63'd0, eow_o}, 64'd1);
    step(0, 0, 16'h0, 1);

    // backpressure
    step(1, 0, 16'h0001, 0);
    step(1, 0, 16'h0002, 0);
    step(1, 0, 16'h0003, 0);
    step(1, 0, 16'h0004, 0);
    held_data = data_o;
    chk("bp_data0", held_data, 64'h0004_0003_0002_0001);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 16'h5555, 0);
      chk("bp_stable_data", data_o, 64'h0004_0003_0002_0001);
      chk("bp_stable_cnt", {61'd0, count_o}, 64'd4);
      chk("bp_rtr_low", {63'd0, rtr_o}, 64'd0);
    end
    step(1, 0, 16'h5555, 1);
    step(1, 0, 16'h5555, 1);
    step(1, 0, 16'h6666, 1);
    step(1, 0, 16'h7777, 1);
    step(1, 0, 16'h8888, 1);
    chk("bp_next_data", data_o, 64'h8888_7777_6666_5555);
    step(0, 0, 16'h0, 1);

    // eow on last slot: one frame, no empty follow-on
    step(1, 0, 16'h000A, 1);
    step(1, 0, 16'h000B, 1);
    step(1, 0, 16'h000C, 1);
    step(1, 1, 16'h000D, 1);
    chk("last_cnt", {61'd0, count_o}, 64'd4);
    chk("last_eow", {63'd0, eow_o}, 64'd1);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    chk("last_no_followon", {63'd0, rts_o}, 64'd0);

    // gaps, eow only while rts low
    step(1, 0, 16'h0101, 1);
    step(0, 1, 16'hDEAD, 1);
    step(1, 0, 16'h0202, 1);
    step(0, 1, 16'hDEAD, 1);
    step(1, 0, 16'h0303, 1);
    step(0, 1, 16'hDEAD, 1);
    step(1, 0, 16'h0404, 1);
    chk("gap_eow", {63'd0, eow_o}, 64'd0);
    chk("gap_cnt", {61'd0, count_o}, 64'd4);
    chk("gap_data", data_o, 64'h0404_0303_0202_0101);
    step(0, 0, 16'h0, 1);

    // reset mid-fill
    step(1, 0, 16'hAAAA, 1);
    step(1, 0, 16'hBBBB, 1);
    rts_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rts", {63'd0, rts_o}, 64'd0);
    chk("mid_rst_cnt", {61'd0, count_o}, 64'd0);
    chk("mid_rst_data", data_o, 64'd0);
    chk("mid_rst_rtr", {63'd0, rtr_o}, 64'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 16'hC001, 1);
    step(1, 0, 16'hC002, 1);
    step(1, 0, 16'hC003, 1);
    step(1, 0, 16'hC004, 1);
    chk("post_rst_data", data_o, 64'hC004_C003_C002_C001);
    chk("post_rst_cnt", {61'd0, count_o}, 64'd4);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
